// File: rtl/svm_pkg.sv
// svm_pkg: shared definitions for the SVM kernel engine.
//   state_e  : kernel engine FSM states
//   klen_f   : width of one kernel value for a given pixel width
//   acc_w_f  : dot-product accumulator width (sized so it cannot overflow)
//   KMAX     : saturation value for the default kernel width
package svm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SQUARE,
        S_STORE,
        S_DONE
    } state_e;

    function automatic int klen_f(input int xlen);
        return 4 * xlen;
    endfunction

    // One bit of headroom beyond the exact sum-of-products bound.
    function automatic int acc_w_f(input int xlen, input int npix);
        return 2 * xlen + $clog2(npix) + 1;
    endfunction

    localparam int                  KLEN_DEF = klen_f(8);
    localparam logic [KLEN_DEF-1:0] KMAX     = '1;

endpackage

// File: rtl/svm_mac_unit.sv
// svm_mac_unit: unsigned multiply-accumulate plus registered squarer.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   clr_i         clear accumulator (wins over acc_en_i)
//   acc_en_i      acc += x_i * sv_i
//   sq_en_i       register acc*acc at full width
//   x_i, sv_i     unsigned pixel operands
//   sq_o          low KLEN bits of the registered square
//   overflow_o    registered square does not fit in KLEN bits
module svm_mac_unit
    import svm_pkg::*;
#(
    parameter int XLEN  = 8,
    parameter int ACC_W = 19,
    parameter int KLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            acc_en_i,
    input  logic            sq_en_i,
    input  logic [XLEN-1:0] x_i,
    input  logic [XLEN-1:0] sv_i,
    output logic [KLEN-1:0] sq_o,
    output logic            overflow_o
);

    localparam int SQ_W = 2 * ACC_W;

    logic [2*XLEN-1:0] prod;
    logic [ACC_W-1:0]  acc_q;
    logic [SQ_W-1:0]   acc_ext;
    logic [SQ_W-1:0]   sq_d;
    logic [SQ_W-1:0]   sq_q;

    assign prod    = x_i * sv_i;
    assign acc_ext = SQ_W'(acc_q);
    assign sq_d    = acc_ext * acc_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            sq_q  <= '0;
        end else begin
            if (clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_q + ACC_W'(prod);
            end
            if (sq_en_i) begin
                sq_q <= sq_d;
            end
        end
    end

    assign sq_o       = sq_q[KLEN-1:0];
    assign overflow_o = |sq_q[SQ_W-1:KLEN];

endmodule

// File: rtl/svm_kernel_engine.sv
// svm_kernel_engine: computes K = (x . sv)^2 for each support vector of a
// cascade stage and packs the results for decision_funct.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   S_IDLE   | waiting for start after reset
//   S_MAC    | accepting pixel pairs, accumulating dot product
//   S_SQUARE | registering acc*acc
//   S_STORE  | writing saturated kernel into slice sv_idx
//   S_DONE   | kernel_out complete, decision_funct_en asserted
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin a new evaluation (honoured in IDLE/DONE)
//   x_pixel, sv_pixel  pixel pair, valid with pixel_valid
//   pixel_ready        engine accepts a pair this cycle
//   busy               evaluation in progress
//   kernel_out         SV0 at the MSB end, SV n at [n*KLEN +: KLEN]
//   decision_funct_en  kernel_out complete and stable
module svm_kernel_engine
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 4,
    parameter int NUM_OF_SV     = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [XLEN_PIXEL-1:0]                       x_pixel,
    input  logic [XLEN_PIXEL-1:0]                       sv_pixel,
    input  logic                                        pixel_valid,
    output logic                                        pixel_ready,
    output logic                                        busy,
    output logic [0:klen_f(XLEN_PIXEL)*NUM_OF_SV-1]     kernel_out,
    output logic                                        decision_funct_en
);

    localparam int KLEN  = klen_f(XLEN_PIXEL);
    localparam int ACC_W = acc_w_f(XLEN_PIXEL, NUM_OF_PIXELS);
    localparam int PIX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int SV_W  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_OF_PIXELS - 1);
    localparam logic [SV_W-1:0]  SV_LAST  = SV_W'(NUM_OF_SV - 1);
    localparam logic [KLEN-1:0]  KSAT     = '1;

    state_e                      state_q, state_d;
    logic [PIX_W-1:0]            pix_cnt_q, pix_cnt_d;
    logic [SV_W-1:0]             sv_idx_q, sv_idx_d;
    logic [0:KLEN*NUM_OF_SV-1]   kernel_q, kernel_d;
    logic                        en_q, en_d;
    logic                        clr, acc_en, sq_en;
    logic [KLEN-1:0]             sq, kval;
    logic                        overflow;

    svm_mac_unit #(
        .XLEN  (XLEN_PIXEL),
        .ACC_W (ACC_W),
        .KLEN  (KLEN)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .acc_en_i   (acc_en),
        .sq_en_i    (sq_en),
        .x_i        (x_pixel),
        .sv_i       (sv_pixel),
        .sq_o       (sq),
        .overflow_o (overflow)
    );

    assign kval = overflow ? KSAT : sq;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        sv_idx_d  = sv_idx_q;
        kernel_d  = kernel_q;
        en_d      = 1'b0;
        clr       = 1'b0;
        acc_en    = 1'b0;
        sq_en     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_MAC;
                    clr       = 1'b1;
                    pix_cnt_d = '0;
                    sv_idx_d  = '0;
                    kernel_d  = '0;
                end else if (state_q == S_DONE) begin
                    // en lags entry to DONE by one edge so kernel_out has
                    // settled a full cycle before the consumer sees it.
                    en_d = 1'b1;
                end
            end
            S_MAC: begin
                if (pixel_valid) begin
                    acc_en = 1'b1;
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        state_d   = S_SQUARE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_SQUARE: begin
                sq_en   = 1'b1;
                state_d = S_STORE;
            end
            S_STORE: begin
                for (int i = 0; i < NUM_OF_SV; i++) begin
                    if (sv_idx_q == SV_W'(i)) begin
                        kernel_d[i*KLEN +: KLEN] = kval;
                    end
                end
                clr = 1'b1;
                if (sv_idx_q == SV_LAST) begin
                    state_d = S_DONE;
                end else begin
                    sv_idx_d = sv_idx_q + 1'b1;
                    state_d  = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            sv_idx_q  <= '0;
            kernel_q  <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            sv_idx_q  <= sv_idx_d;
            kernel_q  <= kernel_d;
            en_q      <= en_d;
        end
    end

    assign pixel_ready       = (state_q == S_MAC);
    assign busy              = (state_q == S_MAC) || (state_q == S_SQUARE) ||
                               (state_q == S_STORE);
    assign kernel_out        = kernel_q;
    assign decision_funct_en = en_q;

endmodule

// File: tb/tb_svm_kernel_engine.sv
module tb_svm_kernel_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x_pixel = '0;
    logic [7:0]  sv_pixel = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready, busy, en;
    logic [0:63] kernel_out;

    logic        start6 = 1'b0;
    logic [7:0]  x6 = '0;
    logic [7:0]  sv6 = '0;
    logic        valid6 = 1'b0;
    logic        ready6, busy6, en6;
    logic [0:95] kernel6;

    int checks = 0;
    int errors = 0;

    logic [7:0] xv  [4];
    logic [7:0] svv [2][4];

    always #5 clk = ~clk;

    svm_kernel_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_pixel(x_pixel),
        .sv_pixel(sv_pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .busy(busy), .kernel_out(kernel_out), .decision_funct_en(en)
    );

    svm_kernel_engine #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(1), .NUM_OF_SV(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .x_pixel(x6),
        .sv_pixel(sv6), .pixel_valid(valid6), .pixel_ready(ready6),
        .busy(busy6), .kernel_out(kernel6), .decision_funct_en(en6)
    );

    task automatic set_case1();
        xv = '{8'd1, 8'd2, 8'd3, 8'd4};
        svv[0] = '{8'd1, 8'd1, 8'd1, 8'd1};
        svv[1] = '{8'd2, 8'd0, 8'd0, 8'd0};
    endtask

    // Runs one evaluation on the default instance, feeding pixel pairs in
    // order and returning edges from the start edge to en observed high.
    task automatic feed(input bit gap, input bit mid_start, input bit chk_drop,
                        output int lat);
        int idx;
        int bubble;
        bit ph;
        idx = 0; bubble = 0; ph = 1'b0; lat = 0;
        @(negedge clk); start = 1'b1; pixel_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        if (chk_drop) begin
            checks++;
            if (en !== 1'b0) begin errors++; $display("FAIL en_drop: got %b want 0", en); end
            checks++;
            if (kernel_out !== 64'h0) begin errors++; $display("FAIL kernel_clear: got %h want 0", kernel_out); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_restart: got %b want 1", busy); end
        end
        while (en !== 1'b1 && lat < 200) begin
            if (bubble > 0) begin
                checks++;
                if (pixel_ready !== 1'b0) begin
                    errors++; $display("FAIL ready_bubble: got %b want 0 (lat %0d)", pixel_ready, lat);
                end
                bubble--;
            end
            ph = ~ph;
            pixel_valid = gap ? ph : 1'b1;
            if (idx < 8) begin
                x_pixel  = xv[idx % 4];
                sv_pixel = svv[idx / 4][idx % 4];
            end
            start = (mid_start && idx == 2);
            if (pixel_valid && pixel_ready) begin
                idx++;
                if (idx % 4 == 0) bubble = 2;
            end
            @(negedge clk); lat++;
        end
        pixel_valid = 1'b0; start = 1'b0;
        checks++;
        if (idx != 8) begin errors++; $display("FAIL beat_count: got %0d want 8", idx); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, pixel_ready, en} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {busy, pixel_ready, en});
        end
        checks++;
        if (kernel_out !== 64'h0) begin errors++; $display("FAIL reset_kernel: got %h want 0", kernel_out); end
        checks++;
        if ({busy6, ready6, en6} !== 3'b000 || kernel6 !== 96'h0) begin
            errors++; $display("FAIL reset_dut6: ctrl %b kernel %h want 0", {busy6, ready6, en6}, kernel6);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        set_case1();
        feed(1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (kernel_out !== 64'h0000_0064_0000_0004) begin
            errors++; $display("FAIL basic_kernel: got %h want 0000006400000004", kernel_out);
        end
        checks++;
        if (lat != 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", lat); end
        checks++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0) begin
            errors++; $display("FAIL done_busy: busy %b ready %b want 0 0", busy, pixel_ready);
        end
    endtask

    task automatic test_saturate();
        int lat;
        xv = '{8'd255, 8'd255, 8'd255, 8'd255};
        svv[0] = '{8'd255, 8'd255, 8'd255, 8'd255};
        svv[1] = '{8'd255, 8'd255, 8'd255, 8'd255};
        feed(1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (kernel_out !== 64'hFFFF_FFFF_FFFF_FFFF || en !== 1'b1) begin
            errors++; $display("FAIL saturate: got %h en %b want ffffffffffffffff en 1", kernel_out, en);
        end
    endtask

    task automatic test_stall();
        int lat;
        set_case1();
        feed(1'b1, 1'b0, 1'b0, lat);
        checks++;
        if (kernel_out !== 64'h0000_0064_0000_0004) begin
            errors++; $display("FAIL stall_kernel: got %h want 0000006400000004", kernel_out);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        set_case1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pixel_valid = 1'b1; x_pixel = xv[i]; sv_pixel = svv[0][i];
            @(negedge clk);
        end
        pixel_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++;
        if ({busy, pixel_ready, en} !== 3'b000 || kernel_out !== 64'h0) begin
            errors++; $display("FAIL mid_reset: ctrl %b kernel %h want 000 0", {busy, pixel_ready, en}, kernel_out);
        end
        feed(1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (kernel_out !== 64'h0000_0064_0000_0004 || lat != 13) begin
            errors++; $display("FAIL rerun: got %h lat %0d want 0000006400000004 lat 13", kernel_out, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_case1();
        feed(1'b0, 1'b1, 1'b0, lat);
        checks++;
        if (kernel_out !== 64'h0000_0064_0000_0004 || lat != 13) begin
            errors++; $display("FAIL mid_start: got %h lat %0d want 0000006400000004 lat 13", kernel_out, lat);
        end
        xv = '{8'd0, 8'd0, 8'd0, 8'd0};
        feed(1'b0, 1'b0, 1'b1, lat);
        checks++;
        if (kernel_out !== 64'h0 || en !== 1'b1) begin
            errors++; $display("FAIL zero_rerun: got %h en %b want 0 en 1", kernel_out, en);
        end
    endtask

    task automatic test_params();
        logic [7:0] xa [3];
        logic [7:0] sa [3];
        int idx;
        int lat;
        xa = '{8'd3, 8'd0, 8'd16};
        sa = '{8'd3, 8'd9, 8'd16};
        idx = 0; lat = 0;
        @(negedge clk); start6 = 1'b1;
        @(negedge clk); start6 = 1'b0;
        while (en6 !== 1'b1 && lat < 200) begin
            valid6 = 1'b1;
            if (idx < 3) begin x6 = xa[idx]; sv6 = sa[idx]; end
            if (ready6) idx++;
            @(negedge clk); lat++;
        end
        valid6 = 1'b0;
        checks++;
        if (kernel6 !== 96'h0000_0051_0000_0000_0001_0000) begin
            errors++; $display("FAIL params_kernel: got %h want 000000510000000000010000", kernel6);
        end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL params_latency: got %0d want 10", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_kernel_engine.md
Name: svm_kernel_engine

Overview:
Producer side of the decision-function interface. Streams test-vector and support-vector pixel pairs, computes a degree-2 polynomial kernel K = (x·sv)^2 per support vector, and packs the NUM_OF_SV kernel values into kernel_out. Raises decision_funct_en once all values are valid. Sits between the pixel/SV memory readers and decision_funct, one instance per cascade stage.

Parameters:
XLEN_PIXEL, 8, bits per unsigned pixel
NUM_OF_PIXELS, 4, pixels per vector (>=1)
NUM_OF_SV, 2, support vectors per stage (>=1)
KLEN, 4*XLEN_PIXEL, width of one kernel value (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a new kernel evaluation
x_pixel  in  XLEN_PIXEL  current test-vector pixel, unsigned
sv_pixel  in  XLEN_PIXEL  current support-vector pixel, unsigned
pixel_valid  in  1  x_pixel/sv_pixel valid this cycle
pixel_ready  out  1  engine accepts a pixel pair this cycle
busy  out  1  evaluation in progress
kernel_out  out  [0:KLEN*NUM_OF_SV-1]  packed kernels; SV0 in bits [0:KLEN-1] (MSB end), SV n in [n*KLEN:(n+1)*KLEN-1]
decision_funct_en  out  1  kernel_out complete and stable

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n. When rst_n=0 at a rising edge: state=IDLE; kernel_out, accumulator, pixel/SV counters, busy, pixel_ready and decision_funct_en all 0. Reset mid-operation aborts the run; no partial result survives.
- FSM states: IDLE, MAC, SQUARE, STORE, DONE.
- IDLE: start=1 moves to MAC, clears accumulator and counters, busy=1.
- MAC: pixel_ready=1. A beat is a cycle with pixel_valid & pixel_ready.
  - Each beat: acc += x_pixel*sv_pixel. Unsigned; acc width 2*XLEN_PIXEL+clog2(NUM_OF_PIXELS)+1, so it never overflows.
  - After the NUM_OF_PIXELS-th beat, go to SQUARE.
  - pixel_valid=0 stalls without side effects.
- SQUARE: sq = acc*acc at full width, registered. pixel_ready=0.
- STORE: writes the kernel value into slice sv_idx of kernel_out.
  - Value is sq if sq < 2^KLEN, else saturates to all ones.
  - Clears acc.
  - If sv_idx = NUM_OF_SV-1, go to DONE; else increment sv_idx and return to MAC.
- DONE: decision_funct_en=1, busy=0, kernel_out held stable. Both stay until start or reset.
- start in DONE: en drops on the next edge, kernel_out slices are cleared, and the engine enters MAC, same as from IDLE.
- start in MAC/SQUARE/STORE: ignored.
- Pixel order per SV is pixel 0 first. SVs are processed in order 0..NUM_OF_SV-1.
- Latency with pixel_valid held high: decision_funct_en rises NUM_OF_SV*(NUM_OF_PIXELS+2)+1 edges after the edge that samples start. That is 13 at defaults.
- Throughput: one pixel pair per cycle in MAC, with a 2-cycle bubble per SV.

Decomposition:
- Shared package svm_pkg holds:
  - FSM state enum
  - KLEN and accumulator-width functions (clog2-based)
  - saturation constant KMAX = all ones of KLEN
- One sub-module, svm_mac_unit: accumulator plus squarer, with clear/accumulate/square controls and outputs sq and overflow. The FSM and packing stay in svm_kernel_engine.

Test Plan:
1. Defaults, pixel_valid always high. x=[1,2,3,4], sv0=[1,1,1,1], sv1=[2,0,0,0] -> kernel_out=64'h0000_0064_0000_0004 (100, 4); en rises 13 edges after start; busy low in DONE.
2. All pixels 255 for both SVs -> dot 260100, square exceeds 2^32-1 -> kernel_out=64'hFFFF_FFFF_FFFF_FFFF, en=1.
3. Case 1 with pixel_valid low on every other cycle -> identical kernel_out; pixel_ready low in SQUARE/STORE; no beat lost or duplicated.
4. rst_n=0 for one cycle after 2 MAC beats of case 1, then rerun case 1 -> all outputs 0 after the reset edge; rerun yields exactly {100,4}, with no stale accumulator.
5. start pulsed during MAC of case 1 -> ignored, result {100,4}. Then start in DONE with x=0 vectors -> en drops next edge, then returns with kernel_out=0.
6. Parameters NUM_OF_PIXELS=1, NUM_OF_SV=3; pairs (3,3),(0,9),(16,16) -> slices 81, 0, 65536; en after 3*(1+2)+1=10 edges.
